// File: rtl/alu_exec_seq_pkg.sv
// Shared ALU op encodings and EX-unit FSM state type, also used by the ALU-control decoder.
package alu_exec_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_SLL     = 4'd2,
    ALU_SLT     = 4'd3,
    ALU_SLTU    = 4'd4,
    ALU_XOR     = 4'd5,
    ALU_SRL     = 4'd6,
    ALU_SRA     = 4'd7,
    ALU_OR      = 4'd8,
    ALU_AND     = 4'd9,
    ALU_NOTEQ   = 4'd10,
    ALU_SGE     = 4'd11,
    ALU_SGEU    = 4'd12,
    ALU_JUMP    = 4'd13,
    ALU_WSY     = 4'd14,
    ALU_ILLEGAL = 4'd15
  } alu_op_e;

  localparam alu_op_e ALU_ILLEGAL_CODE = ALU_ILLEGAL;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_seq_serial_shifter.sv
// One-bit-per-cycle shifter; done pulses in the cycle whose next_val is the final result.
module alu_serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [XLEN-1:0]    op_a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir_right,
  input  logic               arith,
  output logic               done,
  output logic [XLEN-1:0]    next_val
);

  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               arith_q, arith_d;

  always_comb begin
    if (dir_q) next_val = {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
    else       next_val = {work_q[XLEN-2:0], 1'b0};
    // A nonzero counter means a shift is in flight; the last step happens at count 1.
    done    = (cnt_q == SHAMT_W'(1));
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    if (start) begin
      work_d  = op_a;
      cnt_d   = shamt;
      dir_d   = dir_right;
      arith_d = arith;
    end else if (cnt_q != '0) begin
      work_d = next_val;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// EX-stage ALU with valid/ready on both sides and registered result.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts; otherwise shifts run serially.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            accept;

  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (alu_op_e'(op))
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:   r = a << b[SHAMT_W-1:0];
      ALU_SRL:   r = a >> b[SHAMT_W-1:0];
      ALU_SRA:   r = $signed(a) >>> b[SHAMT_W-1:0];
`else
      // Serial build only reaches here for a zero shift amount.
      ALU_SLL, ALU_SRL, ALU_SRA: r = a;
`endif
      ALU_SLT:   r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {{(XLEN-1){1'b0}}, a < b};
      ALU_SGE:   r = {{(XLEN-1){1'b0}}, $signed(a) >= $signed(b)};
      ALU_SGEU:  r = {{(XLEN-1){1'b0}}, a >= b};
      ALU_NOTEQ: r = {{(XLEN-1){1'b0}}, a != b};
      ALU_XOR:   r = a ^ b;
      ALU_OR:    r = a | b;
      ALU_AND:   r = a & b;
      ALU_JUMP:  r = a + XLEN'(4);
      ALU_WSY:   r = b;
      default:   r = '0;
    endcase
    return r;
  endfunction

`ifndef ALU_BARREL_SHIFT_EN
  logic               sh_start;
  logic               sh_done;
  logic [XLEN-1:0]    sh_next;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = op_b[SHAMT_W-1:0];

  alu_serial_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start     (sh_start),
    .op_a      (op_a),
    .shamt     (shamt),
    .dir_right (alu_ctrl != ALU_SLL),
    .arith     (alu_ctrl == ALU_SRA),
    .done      (sh_done),
    .next_val  (sh_next)
  );
`endif

  always_comb begin
    in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    accept      = in_valid && in_ready;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
`ifndef ALU_BARREL_SHIFT_EN
    sh_start    = 1'b0;
`endif
    if ((state_q == ST_DONE) && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end
    if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      if (is_shift_op(alu_ctrl) && (shamt != '0)) begin
        sh_start = 1'b1;
        state_d  = ST_SHIFT;
      end else
`endif
      begin
        result_d    = alu_compute(alu_ctrl, op_a, op_b);
        zero_d      = (result_d == '0);
        illegal_d   = (alu_ctrl == ALU_ILLEGAL_CODE);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
    end
`ifndef ALU_BARREL_SHIFT_EN
    if ((state_q == ST_SHIFT) && sh_done) begin
      result_d    = sh_next;
      zero_d      = (sh_next == '0);
      illegal_d   = 1'b0;
      out_valid_d = 1'b1;
      state_d     = ST_DONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Consumer end of the 4-bit ALU control interface: takes the alu_ctrl code produced by the ALU-control decoder plus two operands, executes the operation and returns a registered result.
- Sits in the EX stage between ID/EX register and EX/MEM register.
- Valid/ready handshake on both sides.
- Shifts run as an iterative 1-bit-per-cycle serial shifter; all other ops complete in one cycle.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request this cycle
- alu_ctrl  in  4  operation code (encodings below)
- op_a  in  XLEN  operand A (rs1 or pc)
- op_b  in  XLEN  operand B (rs2 or immediate)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  alu_ctrl was 4'b1111

Behaviour:
- Encodings:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7
  - OR=8, AND=9, NOTEQ=10, SGE=11, SGEU=12, JUMP=13, WSY=14, ILLEGAL=15
- Function of each code:
  - ADD: a+b. SUB: a-b. Both mod 2^XLEN.
  - SLT / SLTU: {0, a<b}, signed / unsigned.
  - SGE / SGEU: {0, a>=b}, signed / unsigned.
  - NOTEQ: {0, a!=b}.
  - XOR/OR/AND: bitwise.
  - SLL/SRL/SRA: shift by b[SHAMT_W-1:0]; SRA fills with a[XLEN-1].
  - JUMP: a+4 (link address).
  - WSY: b passed through.
  - ILLEGAL: result 0, illegal=1.
- zero and illegal are registered alongside result and valid only while out_valid=1.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, in_valid&&in_ready, non-shift op: compute, load output regs, go to DONE. Latency is 1 cycle (out_valid the cycle after acceptance).
  - IDLE, accept with shift op and shamt==0: result=a, go to DONE (latency 1).
  - IDLE, accept with shift op and shamt>0: latch a, direction and arithmetic flag; counter=shamt; go to SHIFT.
  - SHIFT: shift working register 1 bit per cycle and decrement counter. When counter reaches 0, register the result and go to DONE. Latency is shamt+1 cycles; shamt=31 takes 32 cycles.
  - DONE: out_valid=1. On out_ready, either return to IDLE, or accept a new request in the same cycle (back-to-back).
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from out_ready, and low throughout SHIFT.
- result/zero/illegal hold stable while out_valid && !out_ready.
- Inputs are sampled only on the accept cycle; changes to op_a/op_b/alu_ctrl during SHIFT are ignored.
- Reset:
  - state=IDLE; out_valid=0, result=0, zero=0, illegal=0; shift counter and working register cleared.
  - Reset mid-SHIFT abandons the operation with no output.
  - Reset has priority over a simultaneous accept.

Optional Feature:
- ALU_BARREL_SHIFT_EN defined: shifts use a combinational barrel shifter; every op has latency 1; SHIFT state and counter are not built.
- ALU_BARREL_SHIFT_EN undefined: iterative shifter as above.
- Results are bit-identical in both builds; only latency differs.

Decomposition:
- Shared package/header holds:
  - the 4-bit ALU op encodings (shared with the ALU-control decoder, so no duplicate constants);
  - the FSM state typedef;
  - the ILLEGAL code constant.
- One natural sub-module: alu_serial_shifter (working register, counter, direction/arith flags, done pulse). It is instantiated only when ALU_BARREL_SHIFT_EN is undefined.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, zero=0, out_valid 1 cycle after accept.
- SUB a=b=0x1234 -> result=0, zero=1. Then NOTEQ with the same operands -> result=0.
- SRA a=0x80000000, b=31 -> result=0xFFFFFFFF after 32 cycles, in_ready low throughout. SLL with b=0 -> result=a in 1 cycle.
- Back-to-back: out_ready held 1, alternating XOR/SLTU each cycle -> one result per cycle, no bubbles. SLTU a=1, b=0xFFFFFFFF -> 1; SLT with the same operands -> 0.
- Backpressure: out_ready=0 for 5 cycles after a JUMP with a=0x100 -> result stays 0x104, in_ready=0. Releasing out_ready gives a single handshake.
- alu_ctrl=4'b1111 -> illegal=1, result=0. Asserting rst during SRL with shamt 10, at cycle 3 -> out_valid=0 next cycle, state IDLE, no result emitted.
